counter: RTL and testbench
==========================

COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameters: none; four digits and the segment encoding are fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 sev_seg0  output  7  ones-digit seven-segment pattern.
REQ-005 sev_seg1  output  7  tens-digit seven-segment pattern.
REQ-006 sev_seg2  output  7  hundreds-digit seven-segment pattern.
REQ-007 sev_seg3  output  7  thousands-digit seven-segment pattern.

Function
REQ-008 The block SHALL hold four 4-bit BCD digit registers, named seg0_BCD (ones) through seg3_BCD (thousands), visible hierarchically for benches.
REQ-009 Each rising clk edge with rst=1 SHALL increment the 4-digit decimal value by exactly 1; no enable, and a stopped clock holds the value.
REQ-010 The ones digit SHALL count 0..9; 9 SHALL wrap to 0 and carry into the tens digit in the same edge.
REQ-011 Carry SHALL ripple in the same edge through every digit holding 9 (e.g. 0999 -> 1000).
REQ-012 9999 SHALL wrap to 0000 on the next edge, with no overflow flag.
REQ-013 Digit registers SHALL never hold 10..15; a decoder input of 10..15 SHALL produce all segments off (7'b1111111).
REQ-014 sev_segN SHALL be a purely combinational decode of segN_BCD, so outputs change in the same cycle as the register, with zero added latency.
REQ-015 Segment bit mapping SHALL be bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g; the outputs SHALL be active-low (0 = segment lit).
REQ-016 The patterns SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-017 Leading zeros SHALL be displayed, with no blanking.

Reset
REQ-018 rst=0 SHALL immediately clear all four digits to 0, independent of clk.
REQ-019 During reset, every sev_segN SHALL be 7'b1000000.
REQ-020 Releasing reset SHALL produce a count of 1 on the first rising edge after release.
REQ-021 Reset asserted mid-count, including mid-carry or at 9999, SHALL override the increment and clear to 0000.

Structure
REQ-022 A shared package SHALL hold the ten segment pattern constants, the blank constant and a BCD digit typedef (4 bits).
REQ-023 A single sub-module, bcd_to_7seg (4-bit in, 7-bit out, combinational), SHALL be instantiated four times.
REQ-024 The counter SHALL be one always block on posedge clk / negedge rst, with per-digit carry logic.

Verification
REQ-025 Assert rst=0 with the clock stopped -> digits 0000, all sev_segN = 1000000.
REQ-026 Release reset, then give 10 edges -> digits 0010; sev_seg1=1111001, sev_seg0=1000000.
REQ-027 Gate the clock off for 100 periods -> digits and segments unchanged.
REQ-028 Start from reset and give 1000 edges -> 1000; check the ripple at the 0099->0100 and 0999->1000 edges.
REQ-029 Give 10000 edges -> wrap to 0000; at 9999, all sev_segN = 0010000.
REQ-030 Assert rst between clock edges at count 0057 -> immediate 0000, no wait for an edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and active-low seven-segment patterns (bit0=a .. bit6=g)
// for the four-digit BCD counter.
package counter_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder; codes 10..15 blank.
module bcd_to_7seg
    import counter_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/counter.sv
// Free-running four-digit decimal counter (0000..9999, wraps) driving
// four seven-segment displays with zero-latency decode.
module counter
    import counter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [6:0] sev_seg0,
    output logic [6:0] sev_seg1,
    output logic [6:0] sev_seg2,
    output logic [6:0] sev_seg3
);

    bcd_t seg0_BCD;
    bcd_t seg1_BCD;
    bcd_t seg2_BCD;
    bcd_t seg3_BCD;

    // Carry ripples through every digit sitting at 9 within one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg0_BCD <= '0;
            seg1_BCD <= '0;
            seg2_BCD <= '0;
            seg3_BCD <= '0;
        end else if (seg0_BCD != BCD_MAX) begin
            seg0_BCD <= seg0_BCD + 4'd1;
        end else begin
            seg0_BCD <= '0;
            if (seg1_BCD != BCD_MAX) begin
                seg1_BCD <= seg1_BCD + 4'd1;
            end else begin
                seg1_BCD <= '0;
                if (seg2_BCD != BCD_MAX) begin
                    seg2_BCD <= seg2_BCD + 4'd1;
                end else begin
                    seg2_BCD <= '0;
                    if (seg3_BCD != BCD_MAX)
                        seg3_BCD <= seg3_BCD + 4'd1;
                    else
                        seg3_BCD <= '0;
                end
            end
        end
    end

    bcd_to_7seg u_dec0 (.bcd(seg0_BCD), .seg(sev_seg0));
    bcd_to_7seg u_dec1 (.bcd(seg1_BCD), .seg(sev_seg1));
    bcd_to_7seg u_dec2 (.bcd(seg2_BCD), .seg(sev_seg2));
    bcd_to_7seg u_dec3 (.bcd(seg3_BCD), .seg(sev_seg3));

endmodule

// File: tb/tb_counter.sv
// Directed bench for the four-digit BCD counter and its segment decoder.
module tb_counter;

    logic       clk;
    logic       clk_en;
    logic       rst;
    logic [6:0] sev_seg0, sev_seg1, sev_seg2, sev_seg3;
    logic [3:0] t_bcd;
    logic [6:0] t_seg;

    int n_cmp = 0;
    int n_bad = 0;

    counter dut (
        .clk      (clk),
        .rst      (rst),
        .sev_seg0 (sev_seg0),
        .sev_seg1 (sev_seg1),
        .sev_seg2 (sev_seg2),
        .sev_seg3 (sev_seg3)
    );

    // Standalone decoder to reach the codes the counter never produces.
    bcd_to_7seg u_dec_chk (.bcd(t_bcd), .seg(t_seg));

    // Gated clock: stops wherever it is when clk_en drops (always low here).
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: seg_of = 7'b1000000;
            1: seg_of = 7'b1111001;
            2: seg_of = 7'b0100100;
            3: seg_of = 7'b0110000;
            4: seg_of = 7'b0011001;
            5: seg_of = 7'b0010010;
            6: seg_of = 7'b0000010;
            7: seg_of = 7'b1111000;
            8: seg_of = 7'b0000000;
            9: seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_count(input string tag, input int e);
        int d0, d1, d2, d3;
        d0 = e % 10;
        d1 = (e / 10) % 10;
        d2 = (e / 100) % 10;
        d3 = (e / 1000) % 10;
        chk({tag, ".digits"},
            {16'h0, dut.seg3_BCD, dut.seg2_BCD, dut.seg1_BCD, dut.seg0_BCD},
            {16'h0, 4'(d3), 4'(d2), 4'(d1), 4'(d0)});
        chk({tag, ".segs"},
            {4'h0, sev_seg3, sev_seg2, sev_seg1, sev_seg0},
            {4'h0, seg_of(d3), seg_of(d2), seg_of(d1), seg_of(d0)});
    endtask

    task automatic tick(input int n);
        clk_en = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic stop_clk();
        @(negedge clk);
        clk_en = 1'b0;
        #1;
    endtask

    initial begin
        clk    = 1'b0;
        clk_en = 1'b0;
        rst    = 1'b0;
        t_bcd  = 4'd0;

        // Reset with the clock stopped.
        #20;
        chk_count("reset_idle", 0);
        chk("reset_seg0", {25'h0, sev_seg0}, {25'h0, 7'b1000000});

        // Release and count.
        rst = 1'b1;
        #3;
        tick(1);
        chk_count("first_edge", 1);
        tick(9);
        chk_count("ten_edges", 10);
        chk("ten_seg1", {25'h0, sev_seg1}, {25'h0, 7'b1111001});
        chk("ten_seg0", {25'h0, sev_seg0}, {25'h0, 7'b1000000});

        // Gated clock holds the value.
        stop_clk();
        #1000;
        chk_count("clock_gated", 10);

        // Asynchronous reset between edges at 0057.
        tick(47);
        chk_count("at_0057", 57);
        #2;
        rst = 1'b0;
        #1;
        chk_count("async_rst_0057", 0);
        tick(3);
        chk_count("rst_held_edges", 0);
        stop_clk();
        #2;
        rst = 1'b1;
        #2;
        tick(1);
        chk_count("rerelease_first", 1);

        // Ripple checks on the way to 1000 edges from reset.
        tick(98);
        chk_count("at_0099", 99);
        tick(1);
        chk_count("ripple_0100", 100);
        tick(898);
        chk_count("at_0998", 998);
        tick(1);
        chk_count("at_0999", 999);
        tick(1);
        chk_count("ripple_1000", 1000);

        // 10000 edges from reset: 9999 then wrap.
        tick(8999);
        chk_count("at_9999", 9999);
        chk("seg3_9999", {25'h0, sev_seg3}, {25'h0, 7'b0010000});
        tick(1);
        chk_count("wrap_0000", 0);

        // Reset at 9999 overrides the full-width carry.
        tick(9999);
        chk_count("again_9999", 9999);
        #1;
        rst = 1'b0;
        #1;
        chk_count("rst_at_9999", 0);
        stop_clk();
        rst = 1'b1;
        #2;
        tick(2);
        chk_count("after_9999_rst", 2);
        stop_clk();

        // Decoder: all ten patterns and blanking of illegal codes.
        for (int i = 0; i < 16; i++) begin
            t_bcd = 4'(i);
            #1;
            chk($sformatf("dec_%0d", i), {25'h0, t_seg}, {25'h0, seg_of(i)});
        end
        t_bcd = 4'd12;
        #1;
        chk("dec_blank_lit", {25'h0, t_seg}, {25'h0, 7'b1111111});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
